// File: rtl/ship_life_if.sv
// Ship lifecycle bus: game/collision/animation inputs in, sprite and motion controls out.
interface ship_life_if #(
  parameter int ADDR_W = 14
);
  logic              game_start;
  logic              collision;
  logic              thrust;
  logic              anim_pulse;
  logic [ADDR_W-1:0] anim_base;
  logic [8:0]        sprite_height;
  logic              draw_mask;
  logic              thrust_en;
  logic              respawn;
  logic              vulnerable;
  logic [3:0]        lives;
  logic              game_over;
  logic [2:0]        state;

  modport master (
    output game_start, collision, thrust, anim_pulse,
    input  anim_base, sprite_height, draw_mask, thrust_en, respawn,
           vulnerable, lives, game_over, state
  );

  modport slave (
    input  game_start, collision, thrust, anim_pulse,
    output anim_base, sprite_height, draw_mask, thrust_en, respawn,
           vulnerable, lives, game_over, state
  );
endinterface

// File: rtl/ship_life_ctrl.sv
// Ship lifecycle and sprite animation controller: thrust flame, explosion,
// life counting, respawn delay and blinking invulnerability window.
//
// state          | meaning
// GAME_OVER    0 | no lives left, waiting for game_start
// ALIVE        1 | ship flying, collisions count
// EXPLODING    2 | explosion frames playing
// RESPAWN_WAIT 3 | ship hidden, counting down to respawn
// INVULN       4 | ship blinking, collisions ignored
module ship_life_ctrl #(
  parameter int THRUST_FRAMES  = 4,
  parameter int EXPLODE_FRAMES = 8,
  parameter int FRAME_WORDS    = 1020,
  parameter int EXPLODE_BASE   = 4080,
  parameter int LIVES          = 3,
  parameter int RESPAWN_PULSES = 60,
  parameter int INVULN_PULSES  = 120,
  parameter int BLINK_PULSES   = 4,
  parameter int H_IDLE         = 26,
  parameter int H_THRUST       = 34,
  parameter int H_EXPLODE      = 32,
  parameter int ADDR_W         = 14
) (
  input logic       clk,
  input logic       resetN,
  ship_life_if.slave sl
);

  typedef enum logic [2:0] {
    S_GAME_OVER    = 3'd0,
    S_ALIVE        = 3'd1,
    S_EXPLODING    = 3'd2,
    S_RESPAWN_WAIT = 3'd3,
    S_INVULN       = 3'd4
  } state_t;

  localparam int TF_W    = (THRUST_FRAMES > 1) ? $clog2(THRUST_FRAMES) : 1;
  localparam int EF_W    = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam int CNT_MAX = (RESPAWN_PULSES > INVULN_PULSES) ? RESPAWN_PULSES : INVULN_PULSES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_PULSES + 1);

  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] EB_A    = ADDR_W'(EXPLODE_BASE);
  localparam logic [TF_W-1:0]   TF_LAST = TF_W'(THRUST_FRAMES - 1);
  localparam logic [EF_W-1:0]   EF_LAST = EF_W'(EXPLODE_FRAMES - 1);
  localparam logic [8:0]        HT_IDLE = 9'(H_IDLE);
  localparam logic [8:0]        HT_THR  = 9'(H_THRUST);
  localparam logic [8:0]        HT_EXP  = 9'(H_EXPLODE);

  state_t            st;
  logic [TF_W-1:0]   thrust_frame;
  logic [EF_W-1:0]   explode_frame;
  logic [CNT_W-1:0]  pulse_cnt;
  logic [BLK_W-1:0]  blink_cnt;
  logic [ADDR_W-1:0] anim_base_r;
  logic [8:0]        height_r;
  logic              draw_r, thrust_en_r, respawn_r, vuln_r, game_over_r;
  logic [3:0]        lives_r;

  logic [TF_W-1:0]   thrust_nxt;
  logic [EF_W-1:0]   explode_nxt;
  logic [ADDR_W-1:0] thrust_base, explode_base_nxt;
  logic [3:0]        lives_dec;
  logic              pulse_last, go_invuln;

  always_comb begin
    thrust_nxt = thrust_frame;
    if (!sl.thrust)
      thrust_nxt = '0;
    else if (sl.anim_pulse)
      thrust_nxt = (thrust_frame == TF_LAST) ? '0 : thrust_frame + 1'b1;
    thrust_base      = ADDR_W'(thrust_nxt) * FW_A;
    explode_nxt      = explode_frame + 1'b1;
    explode_base_nxt = EB_A + ADDR_W'(explode_nxt) * FW_A;
    lives_dec        = (lives_r != 4'd0) ? lives_r - 4'd1 : 4'd0;
    // Timers are down-counters; the pulse seen at a count of 1 is the terminal one.
    pulse_last = sl.anim_pulse && (pulse_cnt <= CNT_W'(1));
    go_invuln  = ((st == S_GAME_OVER) && sl.game_start) ||
                 ((st == S_RESPAWN_WAIT) && pulse_last);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      st            <= S_GAME_OVER;
      thrust_frame  <= '0;
      explode_frame <= '0;
      pulse_cnt     <= '0;
      blink_cnt     <= '0;
      anim_base_r   <= '0;
      height_r      <= HT_IDLE;
      draw_r        <= 1'b0;
      thrust_en_r   <= 1'b0;
      respawn_r     <= 1'b0;
      vuln_r        <= 1'b0;
      lives_r       <= 4'd0;
      game_over_r   <= 1'b1;
    end else begin
      respawn_r <= 1'b0;
      case (st)
        S_GAME_OVER: begin
        end
        S_ALIVE: begin
          if (sl.collision) begin
            st            <= S_EXPLODING;
            explode_frame <= '0;
            thrust_frame  <= '0;
            pulse_cnt     <= '0;
            blink_cnt     <= '0;
            anim_base_r   <= EB_A;
            height_r      <= HT_EXP;
            thrust_en_r   <= 1'b0;
            vuln_r        <= 1'b0;
            draw_r        <= 1'b1;
          end else begin
            thrust_frame <= thrust_nxt;
            anim_base_r  <= thrust_base;
            height_r     <= sl.thrust ? HT_THR : HT_IDLE;
            thrust_en_r  <= sl.thrust;
            draw_r       <= 1'b1;
            vuln_r       <= 1'b1;
          end
        end
        S_EXPLODING: begin
          if (sl.anim_pulse) begin
            if (explode_frame == EF_LAST) begin
              lives_r     <= lives_dec;
              anim_base_r <= '0;
              height_r    <= HT_IDLE;
              draw_r      <= 1'b0;
              if (lives_dec == 4'd0) begin
                st          <= S_GAME_OVER;
                game_over_r <= 1'b1;
              end else begin
                st        <= S_RESPAWN_WAIT;
                pulse_cnt <= CNT_W'(RESPAWN_PULSES);
              end
            end else begin
              explode_frame <= explode_nxt;
              anim_base_r   <= explode_base_nxt;
            end
          end
        end
        S_RESPAWN_WAIT: begin
          if (sl.anim_pulse)
            pulse_cnt <= pulse_cnt - 1'b1;
        end
        S_INVULN: begin
          thrust_frame <= thrust_nxt;
          anim_base_r  <= thrust_base;
          height_r     <= sl.thrust ? HT_THR : HT_IDLE;
          thrust_en_r  <= sl.thrust;
          if (sl.anim_pulse) begin
            if (pulse_last) begin
              st        <= S_ALIVE;
              pulse_cnt <= '0;
              blink_cnt <= '0;
              draw_r    <= 1'b1;
              vuln_r    <= 1'b1;
            end else begin
              pulse_cnt <= pulse_cnt - 1'b1;
              if (blink_cnt <= BLK_W'(1)) begin
                draw_r    <= ~draw_r;
                blink_cnt <= BLK_W'(BLINK_PULSES);
              end else begin
                blink_cnt <= blink_cnt - 1'b1;
              end
            end
          end
        end
        default: st <= S_GAME_OVER;
      endcase

      // Both entries into INVULN (new game, respawn) share this setup.
      if (go_invuln) begin
        st           <= S_INVULN;
        pulse_cnt    <= CNT_W'(INVULN_PULSES);
        blink_cnt    <= BLK_W'(BLINK_PULSES);
        thrust_frame <= '0;
        anim_base_r  <= '0;
        height_r     <= sl.thrust ? HT_THR : HT_IDLE;
        thrust_en_r  <= sl.thrust;
        draw_r       <= 1'b1;
        vuln_r       <= 1'b0;
        respawn_r    <= 1'b1;
        game_over_r  <= 1'b0;
        if (st == S_GAME_OVER)
          lives_r <= 4'(LIVES);
      end
    end
  end

  assign sl.anim_base     = anim_base_r;
  assign sl.sprite_height = height_r;
  assign sl.draw_mask     = draw_r;
  assign sl.thrust_en     = thrust_en_r;
  assign sl.respawn       = respawn_r;
  assign sl.vulnerable    = vuln_r;
  assign sl.lives         = lives_r;
  assign sl.game_over     = game_over_r;
  assign sl.state         = st;

endmodule

// File: tb/tb_ship_life_ctrl.sv
// Self-checking bench for ship_life_ctrl with short respawn/invuln timers;
// expected sequences are queued as stimulus is applied and popped on each output.
module tb_ship_life_ctrl;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   e;

  ship_life_if #(.ADDR_W(ADDR_W)) sl();

  ship_life_ctrl #(
    .RESPAWN_PULSES(3),
    .INVULN_PULSES (8),
    .BLINK_PULSES  (2)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .sl    (sl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      sl.anim_pulse = 1'b1;
      tick();
      sl.anim_pulse = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    checks++;
    if ({sl.state, sl.lives, sl.game_over, sl.draw_mask, sl.thrust_en, sl.respawn, sl.vulnerable}
        !== {3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: got st=%0d lives=%0d go=%b dm=%b te=%b rs=%b vu=%b, expected 0 0 1 0 0 0 0",
               sl.state, sl.lives, sl.game_over, sl.draw_mask, sl.thrust_en, sl.respawn, sl.vulnerable);
    end
    checks++;
    if (sl.anim_base !== 14'd0 || sl.sprite_height !== 9'd26) begin
      errors++;
      $display("FAIL reset_sprite: got base=%0d h=%0d, expected 0 26", sl.anim_base, sl.sprite_height);
    end
    resetN = 1'b1;
    sl.collision = 1'b1;
    pulse(2);
    sl.collision = 1'b0;
    checks++;
    if ({sl.state, sl.lives, sl.game_over} !== {3'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL game_over_ignores: got st=%0d lives=%0d go=%b, expected 0 0 1",
               sl.state, sl.lives, sl.game_over);
    end
  endtask

  task automatic test_start();
    sl.game_start = 1'b1;
    tick();
    sl.game_start = 1'b0;
    checks++;
    if ({sl.state, sl.lives, sl.respawn, sl.draw_mask, sl.vulnerable, sl.game_over}
        !== {3'd4, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL start: got st=%0d lives=%0d rs=%b dm=%b vu=%b go=%b, expected 4 3 1 1 0 0",
               sl.state, sl.lives, sl.respawn, sl.draw_mask, sl.vulnerable, sl.game_over);
    end
    tick();
    checks++;
    if (sl.respawn !== 1'b0 || sl.state !== 3'd4) begin
      errors++;
      $display("FAIL start_pulse_width: got rs=%b st=%0d, expected 0 4", sl.respawn, sl.state);
    end
  endtask

  task automatic test_invuln_blink();
    exp_q = {};
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    sl.collision = 1'b1;
    tick();
    sl.collision = 1'b0;
    checks++;
    if (sl.state !== 3'd4 || sl.vulnerable !== 1'b0) begin
      errors++;
      $display("FAIL invuln_collision: got st=%0d vu=%b, expected 4 0", sl.state, sl.vulnerable);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (sl.draw_mask !== e[0]) begin
        errors++;
        $display("FAIL blink_%0d: got dm=%b, expected %0d", i, sl.draw_mask, e);
      end
      pulse(1);
    end
    checks++;
    if ({sl.state, sl.draw_mask, sl.vulnerable} !== {3'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL invuln_exit: got st=%0d dm=%b vu=%b, expected 1 1 1",
               sl.state, sl.draw_mask, sl.vulnerable);
    end
  endtask

  task automatic test_thrust();
    exp_q = {};
    exp_q.push_back(1020); exp_q.push_back(2040); exp_q.push_back(3060);
    exp_q.push_back(0);    exp_q.push_back(1020);
    sl.thrust = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(1);
      e = exp_q.pop_front();
      checks++;
      if (sl.anim_base !== 14'(e) || sl.sprite_height !== 9'd34 || sl.thrust_en !== 1'b1) begin
        errors++;
        $display("FAIL thrust_%0d: got base=%0d h=%0d te=%b, expected %0d 34 1",
                 i, sl.anim_base, sl.sprite_height, sl.thrust_en, e);
      end
    end
    sl.thrust = 1'b0;
    tick();
    checks++;
    if (sl.anim_base !== 14'd0 || sl.sprite_height !== 9'd26 || sl.thrust_en !== 1'b0) begin
      errors++;
      $display("FAIL thrust_drop: got base=%0d h=%0d te=%b, expected 0 26 0",
               sl.anim_base, sl.sprite_height, sl.thrust_en);
    end
  endtask

  task automatic test_explode();
    sl.collision  = 1'b1;
    sl.anim_pulse = 1'b1;
    tick();
    sl.collision  = 1'b0;
    sl.anim_pulse = 1'b0;
    checks++;
    if (sl.state !== 3'd2 || sl.anim_base !== 14'd4080 || sl.sprite_height !== 9'd32 ||
        sl.vulnerable !== 1'b0 || sl.draw_mask !== 1'b1 || sl.thrust_en !== 1'b0) begin
      errors++;
      $display("FAIL explode_entry: got st=%0d base=%0d h=%0d vu=%b dm=%b te=%b, expected 2 4080 32 0 1 0",
               sl.state, sl.anim_base, sl.sprite_height, sl.vulnerable, sl.draw_mask, sl.thrust_en);
    end
    exp_q = {};
    for (int k = 1; k < 8; k++) exp_q.push_back(4080 + 1020 * k);
    for (int i = 0; i < 7; i++) begin
      sl.collision = (i == 2);
      pulse(1);
      sl.collision = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (sl.anim_base !== 14'(e) || sl.state !== 3'd2) begin
        errors++;
        $display("FAIL explode_frame_%0d: got base=%0d st=%0d, expected %0d 2", i + 1, sl.anim_base, sl.state, e);
      end
    end
    pulse(1);
    checks++;
    if ({sl.state, sl.lives, sl.draw_mask} !== {3'd3, 4'd2, 1'b0} || sl.anim_base !== 14'd0) begin
      errors++;
      $display("FAIL explode_done: got st=%0d lives=%0d dm=%b base=%0d, expected 3 2 0 0",
               sl.state, sl.lives, sl.draw_mask, sl.anim_base);
    end
    sl.game_start = 1'b1;
    tick();
    sl.game_start = 1'b0;
    checks++;
    if ({sl.state, sl.lives, sl.respawn} !== {3'd3, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL start_ignored: got st=%0d lives=%0d rs=%b, expected 3 2 0", sl.state, sl.lives, sl.respawn);
    end
    pulse(2);
    checks++;
    if (sl.state !== 3'd3 || sl.respawn !== 1'b0) begin
      errors++;
      $display("FAIL respawn_early: got st=%0d rs=%b, expected 3 0", sl.state, sl.respawn);
    end
    pulse(1);
    checks++;
    if (sl.state !== 3'd4 || sl.respawn !== 1'b1 || sl.draw_mask !== 1'b1) begin
      errors++;
      $display("FAIL respawn: got st=%0d rs=%b dm=%b, expected 4 1 1", sl.state, sl.respawn, sl.draw_mask);
    end
    tick();
    checks++;
    if (sl.respawn !== 1'b0) begin
      errors++;
      $display("FAIL respawn_width: got rs=%b, expected 0", sl.respawn);
    end
  endtask

  task automatic test_game_over();
    pulse(8);
    checks++;
    if (sl.state !== 3'd1) begin
      errors++;
      $display("FAIL back_to_alive: got st=%0d, expected 1", sl.state);
    end
    sl.collision = 1'b1;
    tick();
    sl.collision = 1'b0;
    pulse(8);
    checks++;
    if ({sl.state, sl.lives} !== {3'd3, 4'd1}) begin
      errors++;
      $display("FAIL second_death: got st=%0d lives=%0d, expected 3 1", sl.state, sl.lives);
    end
    pulse(3);
    pulse(8);
    sl.collision = 1'b1;
    tick();
    sl.collision = 1'b0;
    pulse(8);
    checks++;
    if ({sl.state, sl.lives, sl.game_over, sl.draw_mask} !== {3'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL game_over: got st=%0d lives=%0d go=%b dm=%b, expected 0 0 1 0",
               sl.state, sl.lives, sl.game_over, sl.draw_mask);
    end
    sl.collision = 1'b1;
    pulse(4);
    sl.collision = 1'b0;
    checks++;
    if ({sl.state, sl.lives, sl.game_over} !== {3'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL game_over_hold: got st=%0d lives=%0d go=%b, expected 0 0 1",
               sl.state, sl.lives, sl.game_over);
    end
    sl.game_start = 1'b1;
    tick();
    sl.game_start = 1'b0;
    checks++;
    if ({sl.state, sl.lives, sl.game_over} !== {3'd4, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL restart: got st=%0d lives=%0d go=%b, expected 4 3 0", sl.state, sl.lives, sl.game_over);
    end
  endtask

  task automatic test_reset_mid();
    pulse(8);
    sl.collision = 1'b1;
    tick();
    sl.collision = 1'b0;
    pulse(5);
    checks++;
    if (sl.state !== 3'd2 || sl.anim_base !== 14'd9180) begin
      errors++;
      $display("FAIL frame5: got st=%0d base=%0d, expected 2 9180", sl.state, sl.anim_base);
    end
    resetN = 1'b0;
    tick();
    checks++;
    if ({sl.state, sl.lives, sl.game_over, sl.draw_mask, sl.thrust_en, sl.respawn, sl.vulnerable}
        !== {3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} ||
        sl.anim_base !== 14'd0 || sl.sprite_height !== 9'd26) begin
      errors++;
      $display("FAIL reset_mid: got st=%0d lives=%0d go=%b dm=%b te=%b rs=%b vu=%b base=%0d h=%0d, expected 0 0 1 0 0 0 0 0 26",
               sl.state, sl.lives, sl.game_over, sl.draw_mask, sl.thrust_en, sl.respawn,
               sl.vulnerable, sl.anim_base, sl.sprite_height);
    end
    resetN = 1'b1;
  endtask

  initial begin
    sl.game_start = 1'b0;
    sl.collision  = 1'b0;
    sl.thrust     = 1'b0;
    sl.anim_pulse = 1'b0;
    test_reset();
    test_start();
    test_invuln_blink();
    test_thrust();
    test_explode();
    test_game_over();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ship_life_ctrl.md
Name: ship_life_ctrl

Overview:
- Parametrised ship lifecycle and animation controller.
- Generalises the fixed 4-frame thrust-flame counter into a state machine that covers thrust animation, a multi-frame explosion, life counting, the respawn delay and a blinking invulnerability window.
- Sits between collision detection, the motion block and the sprite ROM/draw stage.
- Supplies the ROM frame base address, the sprite height, the draw mask, the motion thrust enable and a respawn pulse.

Parameters:
THRUST_FRAMES, 4, number of thrust-flame animation frames in ROM (≥1)
EXPLODE_FRAMES, 8, number of explosion frames in ROM (≥1)
FRAME_WORDS, 1020, ROM words per frame
EXPLODE_BASE, 4080, ROM word address of explosion frame 0
LIVES, 3, lives granted by game_start (1..15)
RESPAWN_PULSES, 60, anim_pulse count spent in RESPAWN_WAIT
INVULN_PULSES, 120, anim_pulse count spent in INVULN
BLINK_PULSES, 4, anim_pulses per draw-mask toggle in INVULN
H_IDLE, 26, sprite height without flame
H_THRUST, 34, sprite height with flame
H_EXPLODE, 32, sprite height during explosion
ADDR_W, 14, anim_base width

Ports:
clk  in  1  system clock
resetN  in  1  reset; one clock, reset synchronous, active-low
game_start  in  1  single-cycle start request
collision  in  1  ship collision (level, sampled every cycle)
thrust  in  1  accelerator button
anim_pulse  in  1  single-cycle animation tick
anim_base  out  ADDR_W  ROM frame base, added to sprite_addr
sprite_height  out  9  sprite height to draw block
draw_mask  out  1  1 = draw ship
thrust_en  out  1  accelerator gated to motion block
respawn  out  1  single-cycle pulse: motion block recentres and zeroes velocity
vulnerable  out  1  1 = collisions count
lives  out  4  remaining lives
game_over  out  1  1 in GAME_OVER
state  out  3  current state encoding

Behaviour:
- All outputs are registered and respond one cycle after the causing input edge.
- States and encodings: GAME_OVER=0, ALIVE=1, EXPLODING=2, RESPAWN_WAIT=3, INVULN=4.
- Reset (resetN=0 at a clk edge) forces:
  - state=GAME_OVER, lives=0, game_over=1;
  - anim_base=0, sprite_height=H_IDLE;
  - draw_mask=0, thrust_en=0, respawn=0, vulnerable=0;
  - all frame and pulse counters cleared.
- Reset mid-operation aborts any state immediately.
- GAME_OVER:
  - game_start=1 sets lives=LIVES, pulses respawn for one cycle, and moves to INVULN.
  - Other inputs are ignored.
- ALIVE:
  - draw_mask=1, vulnerable=1, thrust_en=thrust.
  - collision=1 moves to EXPLODING with explode frame 0; any anim_pulse in that same cycle is not counted.
- Thrust frame counter (ALIVE and INVULN):
  - While thrust=1, each anim_pulse advances it 0→1→…→THRUST_FRAMES-1→0.
  - thrust=0 clears it to 0.
- anim_base:
  - In ALIVE/INVULN with thrust=1: thrust_frame*FRAME_WORDS, sprite_height=H_THRUST.
  - In ALIVE/INVULN with thrust=0: anim_base=0, sprite_height=H_IDLE.
- EXPLODING:
  - draw_mask=1, vulnerable=0, thrust_en=0, sprite_height=H_EXPLODE.
  - anim_base=EXPLODE_BASE+explode_frame*FRAME_WORDS.
  - Each anim_pulse advances explode_frame.
  - The anim_pulse received while on frame EXPLODE_FRAMES-1 decrements lives. If the decremented value is 0, go to GAME_OVER; otherwise go to RESPAWN_WAIT.
  - collision is ignored.
- RESPAWN_WAIT:
  - draw_mask=0, vulnerable=0, thrust_en=0, anim_base=0.
  - Counts anim_pulses; on pulse number RESPAWN_PULSES, asserts respawn for one cycle and enters INVULN.
- INVULN:
  - vulnerable=0, thrust_en=thrust, collision ignored.
  - Counts anim_pulses. draw_mask starts at 1 and toggles every BLINK_PULSES pulses.
  - On pulse number INVULN_PULSES, goes to ALIVE with draw_mask=1.
- Pulse counters clear on every state entry.
- game_start outside GAME_OVER is ignored.
- Arithmetic:
  - Frame products are computed at ADDR_W bits and truncate silently.
  - Parameters must satisfy EXPLODE_BASE+EXPLODE_FRAMES*FRAME_WORDS ≤ 2^ADDR_W.
- lives never wraps below 0.

Test Plan:
- Reset, then game_start → next cycle: respawn=1 for exactly 1 cycle, state=4, lives=3, draw_mask=1, vulnerable=0.
- Use RESPAWN_PULSES=3, INVULN_PULSES=8, BLINK_PULSES=2. In INVULN apply 8 anim_pulses → draw_mask sequence 1,1,0,0,1,1,0,0, then state=1 with draw_mask=1. collision=1 during INVULN → no state change.
- ALIVE, thrust=1, 5 anim_pulses → anim_base sequence 1020, 2040, 3060, 0, 1020 and sprite_height=34. Drop thrust → anim_base=0, sprite_height=26, thrust_en=0.
- ALIVE, collision together with anim_pulse → state=2, anim_base=4080. Apply 8 anim_pulses → anim_base steps by 1020 up to 11220, then state=3 with lives=2. After 3 more pulses: respawn pulse, state=4.
- Three full death cycles → lives=0, state=0, game_over=1, draw_mask=0. Further collision/anim_pulse → no change. game_start → lives=3.
- resetN=0 while in EXPLODING on frame 5 → next cycle: all outputs at reset values, state=0.
